// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg: op encoding, FSM states, command record and decode helpers for the load/store unit.
package mem_unit_pkg;

    localparam int MU_ADDR_MAX = 64;

    typedef enum logic [3:0] {
        LOAD_BYTE          = 4'h0,
        LOAD_HALF          = 4'h1,
        LOAD_WORD          = 4'h2,
        LOAD_BYTE_UNSIGNED = 4'h4,
        LOAD_HALF_UNSIGNED = 4'h5,
        LOAD_WORD_UNSIGNED = 4'h6,
        STORE_BYTE         = 4'h8,
        STORE_HALF         = 4'h9,
        STORE_WORD         = 4'hA
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } mem_state_t;

    // Store data is at most one word wide, so only 32 bits are kept.
    typedef struct packed {
        op_t                    op;
        logic [MU_ADDR_MAX-1:0] addr;
        logic [31:0]            wdata;
        logic [4:0]             rd;
    } mem_cmd_t;

    function automatic logic is_load(input op_t op);
        return op inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD,
                          LOAD_BYTE_UNSIGNED, LOAD_HALF_UNSIGNED, LOAD_WORD_UNSIGNED};
    endfunction

    function automatic logic is_store(input op_t op);
        return op inside {STORE_BYTE, STORE_HALF, STORE_WORD};
    endfunction

    function automatic logic isunsigned(input op_t op);
        return op inside {LOAD_BYTE_UNSIGNED, LOAD_HALF_UNSIGNED, LOAD_WORD_UNSIGNED};
    endfunction

    function automatic logic [1:0] size_of(input op_t op);
        case (op)
            LOAD_BYTE, LOAD_BYTE_UNSIGNED, STORE_BYTE: return 2'd0;
            LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF: return 2'd1;
            default:                                   return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/mem_unit_lane_extract.sv
// lane_extract: selects the addressed byte/half/word lane of a bus beat and sign- or zero-extends it.
module lane_extract
    import mem_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]            i_rdata,
    input  op_t                        i_op,
    input  logic [$clog2(XLEN/8)-1:0]  i_offset,
    output logic [XLEN-1:0]            o_data
);

    logic [XLEN-1:0] w_shift;

    always_comb begin
        w_shift = i_rdata >> {i_offset, 3'b000};
        case (size_of(i_op))
            2'd0:    o_data = isunsigned(i_op) ? XLEN'(w_shift[7:0])  : XLEN'($signed(w_shift[7:0]));
            2'd1:    o_data = isunsigned(i_op) ? XLEN'(w_shift[15:0]) : XLEN'($signed(w_shift[15:0]));
            default: o_data = isunsigned(i_op) ? XLEN'(w_shift[31:0]) : XLEN'($signed(w_shift[31:0]));
        endcase
    end

endmodule

// File: rtl/mem_unit.sv
// mem_unit: one-at-a-time load/store unit between the memory pipeline stage and a valid/ready data bus.
// Build option MEM_UNIT_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [XLEN-1:0]     cmd_wdata,
    input  logic [4:0]          cmd_rd,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_strb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                rsp_valid,
    output logic [4:0]          rsp_rd,
    output logic [XLEN-1:0]     rsp_data,
    output logic                rsp_err
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    mem_state_t         r_state;
    mem_state_t         w_next;
    mem_cmd_t           r_cmd;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_rsp_data;
    logic               r_rsp_err;

    op_t                w_op;
    logic               w_legal;
    logic               w_trap;
    logic               w_timeout;
    logic [ADDR_W-1:0]  w_cmd_addr;
    logic [ADDR_W-1:0]  w_addr;
    logic [OFF_W-1:0]   w_lane;
    logic [STRB_W-1:0]  w_strb;
    logic [XLEN-1:0]    w_rep;
    logic [XLEN-1:0]    w_ext;

    assign w_op    = op_t'(cmd_op);
    assign w_legal = is_load(w_op) || is_store(w_op);

`ifdef MEM_UNIT_MISALIGN_TRAP_EN
    always_comb begin
        w_cmd_addr = cmd_addr;
        w_trap     = w_legal &&
                     ((size_of(w_op) == 2'd1 && cmd_addr[0]) ||
                      (size_of(w_op) == 2'd2 && cmd_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        w_trap     = 1'b0;
        w_cmd_addr = cmd_addr;
        if (size_of(w_op) != 2'd0) w_cmd_addr[0] = 1'b0;
        if (size_of(w_op) == 2'd2) w_cmd_addr[1] = 1'b0;
    end
`endif

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign w_timeout = 1'b0;
        end else begin : g_timeout
            assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        cmd_ready     = 1'b0;
        mem_req_valid = 1'b0;
        rsp_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = (w_legal && !w_trap) ? REQ : RESP;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_next = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid || w_timeout) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_addr = ADDR_W'(r_cmd.addr);
    assign w_lane = w_addr[OFF_W-1:0];

    always_comb begin
        case (size_of(r_cmd.op))
            2'd0: begin
                w_strb = STRB_W'(1) << w_lane;
                w_rep  = {STRB_W{r_cmd.wdata[7:0]}};
            end
            2'd1: begin
                w_strb = STRB_W'(3) << w_lane;
                w_rep  = {(XLEN/16){r_cmd.wdata[15:0]}};
            end
            default: begin
                w_strb = STRB_W'(15) << w_lane;
                w_rep  = {(XLEN/32){r_cmd.wdata}};
            end
        endcase
    end

    // Bus-side fields are only driven while a request is presented.
    assign mem_we    = mem_req_valid && is_store(r_cmd.op);
    assign mem_addr  = mem_req_valid ? {w_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_strb  = mem_req_valid ? w_strb : '0;
    assign mem_wdata = mem_req_valid ? w_rep  : '0;

    lane_extract #(
        .XLEN (XLEN)
    ) u_lane_extract (
        .i_rdata  (mem_rdata),
        .i_op     (r_cmd.op),
        .i_offset (w_lane),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd      <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_cmd.op    <= w_op;
                        r_cmd.addr  <= MU_ADDR_MAX'(w_cmd_addr);
                        r_cmd.wdata <= cmd_wdata[31:0];
                        r_cmd.rd    <= cmd_rd;
                        r_rsp_data  <= w_trap ? XLEN'(cmd_addr) : '0;
                        r_rsp_err   <= !w_legal || w_trap;
                    end
                end
                REQ: r_cnt <= '0;
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mem_rsp_valid) begin
                        r_rsp_data <= is_load(r_cmd.op) ? w_ext : '0;
                        r_rsp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_rd   = is_load(r_cmd.op) ? r_cmd.rd : 5'd0;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed vectors for mem_unit with a 32-bit (TIMEOUT=4) and a 64-bit instance side by side.
`timescale 1ns/1ps
module tb_mem_unit;
    import mem_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cmd_valid_a, cmd_valid_b;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [4:0]  cmd_rd;
    logic        mem_req_ready, mem_rsp_valid;
    logic [63:0] mem_rdata;

    logic        cmd_ready_a, req_valid_a, we_a, rsp_valid_a, rsp_err_a;
    logic [31:0] addr_a, wdata_a, rsp_data_a;
    logic [3:0]  strb_a;
    logic [4:0]  rsp_rd_a;

    logic        cmd_ready_b, req_valid_b, we_b, rsp_valid_b, rsp_err_b;
    logic [31:0] addr_b;
    logic [63:0] wdata_b, rsp_data_b;
    logic [7:0]  strb_b;
    logic [4:0]  rsp_rd_b;

    logic        sel_b;
    logic        m_ready, m_req, m_we, m_rsp, m_err;
    logic [63:0] m_addr, m_wdata, m_strb, m_data;
    logic [4:0]  m_rd;

    int n_asserts = 0;
    int n_fail    = 0;

    mem_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_dut_a (
        .clk(clk), .reset(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata[31:0]), .cmd_rd(cmd_rd),
        .mem_req_valid(req_valid_a), .mem_req_ready(mem_req_ready), .mem_we(we_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_strb(strb_a),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]),
        .rsp_valid(rsp_valid_a), .rsp_rd(rsp_rd_a), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a)
    );

    mem_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) u_dut_b (
        .clk(clk), .reset(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_rd(cmd_rd),
        .mem_req_valid(req_valid_b), .mem_req_ready(mem_req_ready), .mem_we(we_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_strb(strb_b),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid_b), .rsp_rd(rsp_rd_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b)
    );

    assign m_ready = sel_b ? cmd_ready_b : cmd_ready_a;
    assign m_req   = sel_b ? req_valid_b : req_valid_a;
    assign m_we    = sel_b ? we_b        : we_a;
    assign m_rsp   = sel_b ? rsp_valid_b : rsp_valid_a;
    assign m_err   = sel_b ? rsp_err_b   : rsp_err_a;
    assign m_rd    = sel_b ? rsp_rd_b    : rsp_rd_a;
    assign m_addr  = sel_b ? 64'(addr_b) : 64'(addr_a);
    assign m_wdata = sel_b ? wdata_b     : 64'(wdata_a);
    assign m_strb  = sel_b ? 64'(strb_b) : 64'(strb_a);
    assign m_data  = sel_b ? rsp_data_b  : 64'(rsp_data_a);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Zero-wait transaction: ready in REQ, response on the first WAIT cycle.
    task automatic txn(input bit wide, input logic [3:0] op, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] rdata,
                       input logic e_we, input logic [63:0] e_addr, input logic [63:0] e_strb,
                       input logic [63:0] e_wdata, input logic [4:0] e_rd, input logic [63:0] e_data);
        sel_b = wide;
        cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_rd = rd;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = rdata;
        if (wide) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
        check("idle_ready", m_ready, 1'b1);
        tick();
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
        check("req_valid", m_req, 1'b1);
        check("req_busy", m_ready, 1'b0);
        check("req_we", m_we, e_we);
        check("req_addr", m_addr, e_addr);
        check("req_strb", m_strb, e_strb);
        check("req_wdata", m_wdata, e_wdata);
        tick();
        check("wait_norsp", m_rsp, 1'b0);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check("rsp_valid", m_rsp, 1'b1);
        check("rsp_rd", m_rd, e_rd);
        check("rsp_data", m_data, e_data);
        check("rsp_err", m_err, 1'b0);
        tick();
        check("rsp_pulse", m_rsp, 1'b0);
        check("back_idle", m_ready, 1'b1);
    endtask

    // Command that completes without a bus request (illegal op or trapped misalignment).
    task automatic txn_err(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [4:0] e_rd, input logic [63:0] e_data);
        sel_b = 1'b0;
        cmd_op = op; cmd_addr = addr; cmd_wdata = '0; cmd_rd = rd;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        cmd_valid_a = 1'b1;
        tick();
        cmd_valid_a = 1'b0;
        check("err_noreq", m_req, 1'b0);
        check("err_valid", m_rsp, 1'b1);
        check("err_flag", m_err, 1'b1);
        check("err_data", m_data, e_data);
        check("err_rd", m_rd, e_rd);
        tick();
        check("err_pulse", m_rsp, 1'b0);
        check("err_idle", m_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
        cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = '0;
        sel_b = 1'b0;
        tick();
        tick();
        check("rst_ready", m_ready, 1'b1);
        check("rst_req", m_req, 1'b0);
        check("rst_we", m_we, 1'b0);
        check("rst_strb", m_strb, 64'h0);
        check("rst_addr", m_addr, 64'h0);
        check("rst_wdata", m_wdata, 64'h0);
        check("rst_rsp", m_rsp, 1'b0);
        check("rst_err", m_err, 1'b0);
        check("rst_rd", m_rd, 5'd0);
        check("rst_data", m_data, 64'h0);
        check("rst_b_ready", cmd_ready_b, 1'b1);
        check("rst_b_strb", 64'(strb_b), 64'h0);
        @(negedge clk) rst = 1'b0;
        // stale response after reset must be ignored
        tick();
        check("stale_rsp", m_rsp, 1'b0);
        mem_rsp_valid = 1'b0;

        txn(0, LOAD_BYTE,          32'h1003, 64'h0,    5'd5, 64'h80FF_0000, 0, 64'h1000, 64'h8, 64'h0, 5'd5, 64'hFFFF_FF80);
        txn(0, STORE_HALF,         32'h1002, 64'hBEEF, 5'd7, 64'h0,         1, 64'h1000, 64'hC, 64'hBEEF_BEEF, 5'd0, 64'h0);
        txn(0, LOAD_HALF,          32'h1002, 64'h0,    5'd9, 64'h8001_1234, 0, 64'h1000, 64'hC, 64'h0, 5'd9, 64'hFFFF_8001);
        txn(0, LOAD_BYTE_UNSIGNED, 32'h1001, 64'h0,    5'd1, 64'h0000_F000, 0, 64'h1000, 64'h2, 64'h0, 5'd1, 64'h0000_00F0);
        txn(0, STORE_BYTE,         32'h1001, 64'hAB,   5'd2, 64'h0,         1, 64'h1000, 64'h2, 64'hABAB_ABAB, 5'd0, 64'h0);
        txn(0, LOAD_WORD,          32'h2000, 64'h0,    5'd3, 64'h8765_4321, 0, 64'h2000, 64'hF, 64'h0, 5'd3, 64'h8765_4321);
        txn(0, LOAD_HALF_UNSIGNED, 32'h1000, 64'h0,    5'd4, 64'h1234_8765, 0, 64'h1000, 64'h3, 64'h0, 5'd4, 64'h8765);

`ifdef MEM_UNIT_MISALIGN_TRAP_EN
        txn_err(LOAD_WORD, 32'h1001, 5'd4, 5'd4, 64'h1001);
`else
        txn(0, LOAD_WORD, 32'h1001, 64'h0, 5'd4, 64'h1122_3344, 0, 64'h1000, 64'hF, 64'h0, 5'd4, 64'h1122_3344);
`endif
        txn_err(4'h3, 32'h1000, 5'd6, 5'd0, 64'h0);

        txn(1, LOAD_HALF_UNSIGNED, 32'h1006, 64'h0, 5'd8, 64'h8001_0000_0000_0000, 0, 64'h1000, 64'hC0, 64'h0, 5'd8, 64'h8001);
        txn(1, LOAD_WORD,          32'h1004, 64'h0, 5'd2, 64'h8000_0000_1234_5678, 0, 64'h1000, 64'hF0, 64'h0, 5'd2, 64'hFFFF_FFFF_8000_0000);
        txn(1, STORE_WORD,         32'h1004, 64'h1234_5678, 5'd1, 64'h0, 1, 64'h1000, 64'hF0, 64'h1234_5678_1234_5678, 5'd0, 64'h0);
        txn(1, LOAD_BYTE,          32'h1007, 64'h0, 5'd3, 64'h7F00_0000_0000_00FF, 0, 64'h1000, 64'h80, 64'h0, 5'd3, 64'h7F);

        // request held against a stalled bus, then timeout with no response
        sel_b = 1'b0;
        cmd_op = LOAD_WORD; cmd_addr = 32'h2004; cmd_rd = 5'd9;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        cmd_valid_a = 1'b1;
        tick();
        cmd_valid_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", m_req, 1'b1);
            check("hold_addr", m_addr, 64'h2004);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_wait", m_rsp, 1'b0);
            tick();
        end
        check("to_valid", m_rsp, 1'b1);
        check("to_err", m_err, 1'b1);
        check("to_data", m_data, 64'h0);
        tick();
        check("to_idle", m_ready, 1'b1);

        // reset while a request is presented drops it without waiting for a clock
        cmd_op = LOAD_BYTE; cmd_addr = 32'h3000; cmd_rd = 5'd2;
        cmd_valid_a = 1'b1;
        tick();
        cmd_valid_a = 1'b0;
        check("rq_valid", m_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rq_async_drop", m_req, 1'b0);
        check("rq_async_ready", m_ready, 1'b1);
        @(negedge clk) rst = 1'b0;
        tick();

        // reset in WAIT, then a late response must not produce a completion
        mem_req_ready = 1'b1;
        cmd_valid_a = 1'b1;
        tick();
        cmd_valid_a = 1'b0;
        tick();
        check("rw_in_wait", m_req, 1'b0);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        tick();
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check("rw_no_rsp", m_rsp, 1'b0);
        check("rw_ready", m_ready, 1'b1);
        tick();
        check("rw_no_rsp2", m_rsp, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
